// File: rtl/cnn_pkg.sv
// Shared types and elaboration-time helpers for the CNN layer datapath.
// State encoding for the window scheduler plus output-size and width checks.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic bit addr_fits(input int addr_w, input int img_w, input int img_h);
    return (longint'(1) << addr_w) >= longint'(img_w) * longint'(img_h);
  endfunction

  function automatic bit cnt_fits(input int cnt_w, input int img_w, input int img_h,
                                  input int k);
    int mx;
    mx = (img_w > img_h) ? img_w : img_h;
    mx = (k > mx) ? k : mx;
    return (longint'(1) << cnt_w) > longint'(mx);
  endfunction

endpackage

// File: rtl/conv_window_sched_wrap_counter.sv
// Modulo-limit loop counter; wrap is combinational so carries ripple
// through a counter chain within one cycle.
module wrap_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         ce,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = ce && (count == limit - W'(1));

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      count <= '0;
    end else if (clear || wrap) begin
      count <= '0;
    end else if (ce) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_sched.sv
// Convolution loop-nest scheduler: walks out_row/out_col/k_row/k_col and
// issues one feature-map read address per tap, multiplier-free.
//
// state   | meaning
// IDLE    | waiting for i_start, all counters and bases zero
// RUN     | issuing taps, one per unstalled cycle
// DONE    | one-cycle completion pulse
module conv_window_sched
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 5
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_stall,
  output logic                 o_busy,
  output logic                 o_rd_valid,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic [2*CNT_W-1:0]   o_k_idx,
  output logic                 o_first,
  output logic                 o_last,
  output logic [CNT_W-1:0]     o_out_row,
  output logic [CNT_W-1:0]     o_out_col,
  output logic                 o_done
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);

  localparam logic [CNT_W-1:0]  LIM_K    = CNT_W'(K);
  localparam logic [CNT_W-1:0]  LIM_OW   = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0]  LIM_OH   = CNT_W'(OUT_H);
  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(STRIDE * IMG_W);

  sched_state_t state, state_nxt;

  logic             run, adv;
  logic [CNT_W-1:0] k_col, k_row, out_col, out_row;
  logic             wrap_kc, wrap_kr, wrap_oc, wrap_or;

  // Base registers: k_row*IMG_W, out_col*STRIDE, out_row*STRIDE*IMG_W.
  logic [ADDR_W-1:0] kr_off, oc_base, or_base;

  assign run = (state == ST_RUN);
  assign adv = run && !i_stall && !i_clear;

  wrap_counter #(.W(CNT_W)) u_k_col (
    .clk(clk), .global_rst_n(global_rst_n), .ce(adv), .clear(i_clear),
    .limit(LIM_K), .count(k_col), .wrap(wrap_kc)
  );

  wrap_counter #(.W(CNT_W)) u_k_row (
    .clk(clk), .global_rst_n(global_rst_n), .ce(wrap_kc), .clear(i_clear),
    .limit(LIM_K), .count(k_row), .wrap(wrap_kr)
  );

  wrap_counter #(.W(CNT_W)) u_out_col (
    .clk(clk), .global_rst_n(global_rst_n), .ce(wrap_kr), .clear(i_clear),
    .limit(LIM_OW), .count(out_col), .wrap(wrap_oc)
  );

  wrap_counter #(.W(CNT_W)) u_out_row (
    .clk(clk), .global_rst_n(global_rst_n), .ce(wrap_oc), .clear(i_clear),
    .limit(LIM_OH), .count(out_row), .wrap(wrap_or)
  );

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (i_start) state_nxt = ST_RUN;
      ST_RUN:  if (wrap_or) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (i_clear) state_nxt = ST_IDLE;
  end

  // Wraps only fire on an advance, so the carries alone pace the bases.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      kr_off  <= '0;
      oc_base <= '0;
      or_base <= '0;
    end else if (i_clear) begin
      kr_off  <= '0;
      oc_base <= '0;
      or_base <= '0;
    end else begin
      if (wrap_kr)      kr_off <= '0;
      else if (wrap_kc) kr_off <= kr_off + ROW_STEP;

      if (wrap_oc)      oc_base <= '0;
      else if (wrap_kr) oc_base <= oc_base + COL_STEP;

      if (wrap_or)      or_base <= '0;
      else if (wrap_oc) or_base <= or_base + WIN_STEP;
    end
  end

  assign o_rd_addr  = or_base + kr_off + oc_base + ADDR_W'(k_col);
  assign o_k_idx    = {k_row, k_col};
  assign o_out_row  = out_row;
  assign o_out_col  = out_col;
  assign o_busy     = run;
  assign o_rd_valid = run && !i_stall;
  assign o_first    = run && (k_row == '0) && (k_col == '0);
  assign o_last     = run && (k_row == LIM_K - CNT_W'(1)) && (k_col == LIM_K - CNT_W'(1));
  assign o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench: a 6x6/K3/S1 and a 7x7/K3/S2 scheduler share one clock;
// expected taps are queued per pass and popped as the DUT issues them.
module tb_conv_window_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic global_rst_n;
  logic i_start_a, i_clear_a, i_stall_a;
  logic i_start_b, i_clear_b, i_stall_b;

  logic        o_busy_a, o_rd_valid_a, o_first_a, o_last_a, o_done_a;
  logic [9:0]  o_rd_addr_a, o_k_idx_a;
  logic [4:0]  o_out_row_a, o_out_col_a;
  logic        o_busy_b, o_rd_valid_b, o_first_b, o_last_b, o_done_b;
  logic [9:0]  o_rd_addr_b, o_k_idx_b;
  logic [4:0]  o_out_row_b, o_out_col_b;

  conv_window_sched #(.IMG_W(6), .IMG_H(6), .K(3), .STRIDE(1), .ADDR_W(10), .CNT_W(5)) u_dut_a (
    .clk(clk), .global_rst_n(global_rst_n),
    .i_start(i_start_a), .i_clear(i_clear_a), .i_stall(i_stall_a),
    .o_busy(o_busy_a), .o_rd_valid(o_rd_valid_a), .o_rd_addr(o_rd_addr_a),
    .o_k_idx(o_k_idx_a), .o_first(o_first_a), .o_last(o_last_a),
    .o_out_row(o_out_row_a), .o_out_col(o_out_col_a), .o_done(o_done_a)
  );

  conv_window_sched #(.IMG_W(7), .IMG_H(7), .K(3), .STRIDE(2), .ADDR_W(10), .CNT_W(5)) u_dut_b (
    .clk(clk), .global_rst_n(global_rst_n),
    .i_start(i_start_b), .i_clear(i_clear_b), .i_stall(i_stall_b),
    .o_busy(o_busy_b), .o_rd_valid(o_rd_valid_b), .o_rd_addr(o_rd_addr_b),
    .o_k_idx(o_k_idx_b), .o_first(o_first_b), .o_last(o_last_b),
    .o_out_row(o_out_row_b), .o_out_col(o_out_col_b), .o_done(o_done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tap_word(input int addr, input int kr, input int kc,
                                           input logic first, input logic last,
                                           input int orow, input int ocol);
    logic [31:0] w;
    w = {addr[9:0], kr[4:0], kc[4:0], first, last, orow[4:0], ocol[4:0]};
    return w;
  endfunction

  logic [31:0] obs_a, obs_b;
  assign obs_a = tap_word(int'(o_rd_addr_a), int'(o_k_idx_a[9:5]), int'(o_k_idx_a[4:0]),
                          o_first_a, o_last_a, int'(o_out_row_a), int'(o_out_col_a));
  assign obs_b = tap_word(int'(o_rd_addr_b), int'(o_k_idx_b[9:5]), int'(o_k_idx_b[4:0]),
                          o_first_b, o_last_b, int'(o_out_row_b), int'(o_out_col_b));

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  int cyc = 0;
  int taps_a = 0, taps_b = 0, done_a = 0, done_b = 0;
  int last_vcyc_a = 0, last_vcyc_b = 0;
  int last_addr_a = 0, last_orow_a = 0, last_ocol_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_rd_valid_a) begin
      check("sb_nonempty_a", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) check("tap_a", obs_a, qa.pop_front());
      check("busy_with_valid_a", 32'(o_busy_a), 32'd1);
      taps_a      <= taps_a + 1;
      last_vcyc_a <= cyc;
      last_addr_a <= int'(o_rd_addr_a);
      last_orow_a <= int'(o_out_row_a);
      last_ocol_a <= int'(o_out_col_a);
    end
    if (i_stall_a) check("valid_in_stall_a", 32'(o_rd_valid_a), 32'd0);
    if (o_done_a) begin
      done_a <= done_a + 1;
      check("done_gap_a", 32'(cyc - last_vcyc_a), 32'd1);
      check("busy_at_done_a", 32'(o_busy_a), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (o_rd_valid_b) begin
      check("sb_nonempty_b", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) check("tap_b", obs_b, qb.pop_front());
      if (o_first_b && o_out_row_b == 5'd1 && o_out_col_b == 5'd1)
        check("win11_first_b", 32'(o_rd_addr_b), 32'd16);
      if (o_last_b && o_out_row_b == 5'd1 && o_out_col_b == 5'd1)
        check("win11_last_b", 32'(o_rd_addr_b), 32'd32);
      taps_b      <= taps_b + 1;
      last_vcyc_b <= cyc;
    end
    if (i_stall_b) check("valid_in_stall_b", 32'(o_rd_valid_b), 32'd0);
    if (o_done_b) begin
      done_b <= done_b + 1;
      check("done_gap_b", 32'(cyc - last_vcyc_b), 32'd1);
      check("busy_at_done_b", 32'(o_busy_b), 32'd0);
    end
  end

  // Reference loop nest, written directly from the address formula.
  task automatic model_pass(input int which);
    int w, h, k, s, ow, oh, addr;
    logic [31:0] word;
    w = (which == 0) ? 6 : 7;
    h = w;
    k = 3;
    s = (which == 0) ? 1 : 2;
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int orow = 0; orow < oh; orow++)
      for (int ocol = 0; ocol < ow; ocol++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            addr = (orow * s + kr) * w + ocol * s + kc;
            word = tap_word(addr, kr, kc, (kr == 0 && kc == 0), (kr == k-1 && kc == k-1),
                            orow, ocol);
            if (which == 0) qa.push_back(word);
            else            qb.push_back(word);
          end
  endtask

  task automatic drive(input int which, input logic st, input logic cl, input logic sl);
    if (which == 0) begin
      i_start_a = st; i_clear_a = cl; i_stall_a = sl;
    end else begin
      i_start_b = st; i_clear_b = cl; i_stall_b = sl;
    end
  endtask

  task automatic run_pass(input int which, input int pct, input int exp_taps);
    int t0, d0, budget;
    t0 = (which == 0) ? taps_a : taps_b;
    d0 = (which == 0) ? done_a : done_b;
    model_pass(which);
    @(posedge clk); #1;
    drive(which, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    budget = 0;
    while (((which == 0) ? done_a : done_b) == d0 && budget < 3000) begin
      drive(which, 1'b0, 1'b0, ($urandom_range(0, 99) < pct));
      @(posedge clk); #1;
      budget++;
    end
    drive(which, 1'b0, 1'b0, 1'b0);
    check("done_seen", 32'(((which == 0) ? done_a : done_b) - d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 32'(((which == 0) ? done_a : done_b) - d0), 32'd1);
    check("tap_count", 32'(((which == 0) ? taps_a : taps_b) - t0), 32'(exp_taps));
    check("sb_drained", 32'((which == 0) ? qa.size() : qb.size()), 32'd0);
  endtask

  task automatic wait_taps_a(input int t0, input int n);
    int budget;
    budget = 0;
    while (taps_a - t0 < n && budget < 500) begin
      @(negedge clk); #2;
      budget++;
    end
    check("reach_tap", 32'(taps_a - t0), 32'(n));
  endtask

  initial begin
    int t0, d0;
    global_rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy_a), 32'd0);
    check("rst_valid", 32'(o_rd_valid_a), 32'd0);
    check("rst_flags", 32'({o_first_a, o_last_a, o_done_a}), 32'd0);
    check("rst_addr", 32'(o_rd_addr_a), 32'd0);
    check("rst_kidx", 32'(o_k_idx_a), 32'd0);
    check("rst_out_rc", 32'({o_out_row_a, o_out_col_a}), 32'd0);
    check("rst_b_all", 32'({o_busy_b, o_rd_valid_b, o_done_b, o_rd_addr_b}), 32'd0);
    global_rst_n = 1'b1;

    run_pass(0, 0, 144);
    check("last_addr_a", 32'(last_addr_a), 32'd35);
    check("last_out_rc_a", 32'({last_orow_a[4:0], last_ocol_a[4:0]}), 32'({5'd3, 5'd3}));

    run_pass(0, 30, 144);
    run_pass(1, 0, 81);

    // Abort at tap 50 with a stray start at tap 20 that must be ignored.
    t0 = taps_a;
    d0 = done_a;
    model_pass(0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_taps_a(t0, 20);
    i_start_a = 1'b1;
    @(negedge clk); #2;
    i_start_a = 1'b0;
    wait_taps_a(t0, 50);
    i_clear_a = 1'b1;
    @(posedge clk); #1;
    i_clear_a = 1'b0;
    check("clear_busy", 32'(o_busy_a), 32'd0);
    check("clear_addr", 32'(o_rd_addr_a), 32'd0);
    check("clear_kidx", 32'(o_k_idx_a), 32'd0);
    @(negedge clk); #2;
    check("clear_taps", 32'(taps_a - t0), 32'd50);
    qa.delete();
    repeat (5) @(posedge clk);
    #1;
    check("clear_no_done", 32'(done_a - d0), 32'd0);

    run_pass(0, 0, 144);

    t0 = taps_a;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    check("clr_start_idle", 32'(o_busy_a), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_start_no_taps", 32'(taps_a - t0), 32'd0);

    // Asynchronous reset mid-pass.
    t0 = taps_a;
    d0 = done_a;
    model_pass(0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_taps_a(t0, 30);
    global_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy_a), 32'd0);
    check("arst_valid", 32'(o_rd_valid_a), 32'd0);
    check("arst_flags", 32'({o_first_a, o_last_a, o_done_a}), 32'd0);
    check("arst_addr", 32'(o_rd_addr_a), 32'd0);
    check("arst_kidx", 32'(o_k_idx_a), 32'd0);
    check("arst_out_rc", 32'({o_out_row_a, o_out_col_a}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    global_rst_n = 1'b1;
    qa.delete();
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_done", 32'(done_a - d0), 32'd0);

    run_pass(0, 0, 144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
